i2c_slave_regs: RTL and testbench
=================================

// Module: i2c_slave_regs
// PURPOSE
//  Parametrised I2C slave in the clk domain. Oversamples scl/sda and decodes START, STOP and repeated START.
//  Holds NUM_REGS 8-bit registers that the bus can write in bursts and read back.
//  Register 0 drives the board LEDs. Successor to the LED-only slave: adds an address match,
//  a register pointer with auto-increment, and read support.
// PARAMETERS
//  SLAVE_ADDR  7'h42  7-bit bus address this slave ACKs
//  NUM_REGS    4      register count; power of 2, 2..256
//  LED_WIDTH   8      led width, 1..8; led = reg[0][LED_WIDTH-1:0]
// PORTS
//  clk         in   1          system clock; must be >= 20x scl frequency
//  rst         in   1          synchronous, active-high reset
//  scl_in      in   1          bus clock, async; master-only, no clock stretching
//  sda_in      in   1          bus data, async
//  sda_oe      out  1          1 = pull SDA low (open drain); 0 = release
//  led         out  LED_WIDTH  reg[0] low bits
//  busy        out  1          1 from START until STOP
//  wr_strobe   out  1          1-clk pulse per register written
// BEHAVIOUR
//  - Reset: all regs 0, pointer 0, state IDLE. sda_oe=0, led=0, busy=0, wr_strobe=0.
//  - Sync/edges: scl and sda each pass a 2-FF synchroniser.
//    Edges are detected on the synced values (prev vs cur).
//  - START/Sr: sda falls while scl high. Go to ADDR, clear bit count, sda_oe=0, busy=1.
//    Accepted in any state.
//  - STOP: sda rises while scl high. Go to IDLE, sda_oe=0, busy=0 in any state.
//    A partial byte is discarded.
//  - Bits are MSB first. Sample sda on synced scl rise.
//    Change sda_oe only on the clk after a synced scl fall.
//  - States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
//  - ADDR: shift 8 bits (7-bit address + R/W).
//    Match + W -> ADDR_ACK, then PTR.
//    Match + R -> ADDR_ACK, then RDATA.
//    Mismatch -> WAIT_STOP; no ACK, sda untouched.
//  - *_ACK: drive sda_oe=1 from the scl fall after bit 8 to the next scl fall (one ACK clock).
//  - PTR: the received byte sets pointer = byte mod NUM_REGS. ACK, then WDATA.
//  - WDATA: after the 8th bit sample, reg[ptr] <= byte and wr_strobe pulses for 1 clk.
//    led updates on the next clk. Pointer += 1, wrapping NUM_REGS-1 -> 0. ACK, then WDATA.
//  - RDATA: load the shift register with reg[ptr] at entry, then drive each bit on scl fall:
//    sda_oe = ~bit. After 8 bits, release sda and go to RDATA_ACK.
//  - RDATA_ACK: sample master ACK on scl rise. Pointer += 1 (wrap).
//    ACK (0) -> RDATA with the next reg. NACK (1) -> WAIT_STOP with sda released.
//  - WAIT_STOP: ignore bits; leave only on STOP or Sr.
//  - Sr after a PTR write followed by address+R reads from the stored pointer.
//  - Reset mid-transfer returns everything to reset values on the next clk.
//    The bus is released immediately.
//  - Simultaneous events: STOP/START detection has priority over any bit sample in the same clk.
// TESTING
//  1. START, 0x84 (0x42+W), ptr 0x00, data 0xA5, STOP
//     -> 3 ACKs (sda_oe=1 in each ACK clock), led=0xA5, one wr_strobe.
//  2. START, 0x86 (0x43+W), data 0xFF, STOP
//     -> sda_oe stays 0 throughout, led unchanged, no wr_strobe.
//  3. Write ptr 0x03, data 0x11, 0x22
//     -> reg3=0x11, reg0=0x22 (wrap), led=0x22, two wr_strobes.
//  4. Write ptr 0x01, Sr, 0x85, read 2 bytes (ACK then NACK) with reg1=0x5A, reg2=0xC3
//     -> bus bits 0x5A then 0xC3; sda released after the NACK; busy=0 after STOP.
//  5. STOP after 4 data bits -> state IDLE, no register change, busy=0.
//  6. rst=1 during the data byte of a write -> next clk: led=0, sda_oe=0, busy=0.
//     A new transaction after that works normally.

Source files
------------

// File: rtl/i2c_slave_regs.sv
// Purpose: I2C slave exposing NUM_REGS 8-bit registers (burst write, auto-increment read); reg0 drives led.
// Latency: bus events act 3 clk after the pin edge (2-FF sync + edge detect); reg write and wr_strobe on the 8th-bit sample.
// Backpressure: none; the master paces every bit and the slave never stretches scl.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         NUM_REGS   = 4,
  parameter int         LED_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scl_in,
  input  logic                 sda_in,
  output logic                 sda_oe,
  output logic [LED_WIDTH-1:0] led,
  output logic                 busy,
  output logic                 wr_strobe
);

  localparam int PW = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP
  } state_t;

  // pipe[0]/[1] form the synchroniser, [1] is the current value, [2] the previous one
  logic [2:0]    scl_pipe_q, scl_pipe_d;
  logic [2:0]    sda_pipe_q, sda_pipe_d;
  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [7:0]    regs_q [NUM_REGS];
  logic [7:0]    regs_d [NUM_REGS];
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_strobe_q, wr_strobe_d;

  logic       scl_cur, scl_prev, sda_cur, sda_prev;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;

  assign scl_cur   = scl_pipe_q[1];
  assign scl_prev  = scl_pipe_q[2];
  assign sda_cur   = sda_pipe_q[1];
  assign sda_prev  = sda_pipe_q[2];
  assign scl_rise  = scl_cur & ~scl_prev;
  assign scl_fall  = ~scl_cur & scl_prev;
  assign start_det = scl_cur & scl_prev & sda_prev & ~sda_cur;
  assign stop_det  = scl_cur & scl_prev & ~sda_prev & sda_cur;
  // byte as it stands once the bit being sampled now is shifted in
  assign byte_in   = {shift_q[6:0], sda_cur};

  // Synchroniser shift: the pins advance one stage per clk
  always_comb begin
    scl_pipe_d = {scl_pipe_q[1:0], scl_in};
    sda_pipe_d = {sda_pipe_q[1:0], sda_in};
  end

  // Protocol FSM: START/STOP first, then per-state bit handling on synced scl edges
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    regs_d      = regs_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    if (stop_det) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else begin
      unique case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == ADDR && byte_in[7:1] != SLAVE_ADDR) begin
                state_d = WAIT_STOP;
              end
              if (state_q == PTR) begin
                ptr_d = byte_in[PW-1:0];
              end
              if (state_q == WDATA) begin
                regs_d[ptr_q] = byte_in;
                wr_strobe_d   = 1'b1;
                ptr_d         = ptr_q + PW'(1);
              end
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            // the scl fall after bit 8 opens the ACK clock
            sda_oe_d  = 1'b1;
            bit_cnt_d = '0;
            state_d   = (state_q == ADDR) ? ADDR_ACK : (state_q == PTR) ? PTR_ACK : WDATA_ACK;
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            // shift_q[0] still holds the R/W bit of the address byte
            if (state_q == ADDR_ACK && shift_q[0]) begin
              shift_d   = regs_q[ptr_q];
              sda_oe_d  = ~regs_q[ptr_q][7];
              bit_cnt_d = 4'd1;
              state_d   = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = (state_q == ADDR_ACK) ? PTR : WDATA;
            end
          end
        end
        RDATA: begin
          // bit_cnt counts bits already placed on the bus
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = RDATA_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        RDATA_ACK: begin
          // bit_cnt=1 marks a master ACK seen; the next byte goes out on the following fall
          if (scl_rise) begin
            ptr_d = ptr_q + PW'(1);
            if (sda_cur) begin
              state_d = WAIT_STOP;
            end else begin
              bit_cnt_d = 4'd1;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            shift_d  = regs_q[ptr_q];
            sda_oe_d = ~regs_q[ptr_q][7];
            state_d  = RDATA;
          end
        end
        IDLE, WAIT_STOP: begin
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_pipe_q  <= 3'b111;
      sda_pipe_q  <= 3'b111;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      scl_pipe_q  <= scl_pipe_d;
      sda_pipe_q  <= sda_pipe_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      regs_q      <= regs_d;
    end
  end

  // rst gates the driver so the bus is let go without waiting for a clk
  assign sda_oe    = sda_oe_q & ~rst;
  assign led       = regs_q[0][LED_WIDTH-1:0];
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Purpose: bench for i2c_slave_regs; a bit-banged master plus scoreboard monitors on the bus and wr_strobe.
// Latency: master holds each scl phase 10 clk, far above the slave's 3-clk reaction time.
// Backpressure: none; the master never waits on the slave.
module tb_i2c_slave_regs;

  localparam int Q = 5;  // quarter-ish step: half an scl phase

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] led;
  logic       busy;
  logic       wr_strobe;

  int errors = 0;
  int checks = 0;
  int oe_hi_cnt = 0;
  logic mon_en = 1'b0;
  logic exp_bus [$];
  logic [7:0] exp_wr [$];

  // open-drain bus: either side can pull low
  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_regs #(.SLAVE_ADDR(7'h42), .NUM_REGS(4), .LED_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .led(led), .busy(busy), .wr_strobe(wr_strobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  // one scl clock; entry and exit with scl low. chk queues the bus level expected at the rise
  task automatic bit_cycle(input logic b, input logic chk, input logic expb);
    sda_m = b;
    wait_clk(Q);
    if (chk) exp_bus.push_back(expb);
    mon_en = chk;
    scl_m = 1'b1;
    wait_clk(2 * Q);
    scl_m = 1'b0;
    mon_en = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(2 * Q);
  endtask

  // master sends a byte, then releases sda for the slave's ACK (0) or silence (1)
  task automatic wr_byte(input logic [7:0] b, input logic exp_ack);
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], 1'b0, 1'b0);
    bit_cycle(1'b1, 1'b1, ~exp_ack);
  endtask

  // data byte that must produce one wr_strobe with led == led_after one clk later
  task automatic wr_data(input logic [7:0] b, input logic [7:0] led_after);
    exp_wr.push_back(led_after);
    wr_byte(b, 1'b1);
  endtask

  // master releases sda for 8 bits and expects exp on the bus, then sends ACK/NACK
  task automatic rd_byte(input logic [7:0] exp, input logic ack);
    for (int i = 7; i >= 0; i--) bit_cycle(1'b1, 1'b1, exp[i]);
    bit_cycle(~ack, 1'b0, 1'b0);
  endtask

  // Bus monitor: compare sda at every checked scl rise against the queued expectation
  always begin
    logic e;
    @(posedge scl_m);
    #2;
    if (mon_en) begin
      if (exp_bus.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_bit_unqueued: got %0b expected none", sda_line);
      end else begin
        e = exp_bus.pop_front();
        check("bus_bit", sda_line, e);
      end
    end
  end

  // Write monitor: every wr_strobe consumes one expectation; strobe is 1 clk wide
  always begin
    logic [7:0] e;
    @(negedge clk);
    if (wr_strobe === 1'b1) begin
      if (exp_wr.size() == 0) begin
        check("wr_strobe_unexpected", wr_strobe, 0);
      end else begin
        e = exp_wr.pop_front();
        @(negedge clk);
        check("wr_strobe_width", wr_strobe, 0);
        check("led_after_write", led, e);
      end
    end
  end

  always @(negedge clk) if (sda_oe === 1'b1) oe_hi_cnt++;

  initial begin
    int oe_before;
    wait_clk(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_led", led, 0);
    check("reset_busy", busy, 0);
    check("reset_wr_strobe", wr_strobe, 0);
    wait_clk(4);

    // 1: write 0xA5 to reg0
    i2c_start();
    check("t1_busy_after_start", busy, 1);
    wr_byte(8'h84, 1'b1);
    wr_byte(8'h00, 1'b1);
    wr_data(8'hA5, 8'hA5);
    i2c_stop();
    check("t1_busy_after_stop", busy, 0);
    check("t1_led", led, 8'hA5);

    // 2: foreign address; slave stays silent
    oe_before = oe_hi_cnt;
    i2c_start();
    wr_byte(8'h86, 1'b0);
    wr_byte(8'hFF, 1'b0);
    i2c_stop();
    check("t2_sda_oe_quiet", oe_hi_cnt - oe_before, 0);
    check("t2_led_unchanged", led, 8'hA5);

    // 3: burst wraps from reg3 to reg0
    i2c_start();
    wr_byte(8'h84, 1'b1);
    wr_byte(8'h03, 1'b1);
    wr_data(8'h11, 8'hA5);
    wr_data(8'h22, 8'h22);
    i2c_stop();
    check("t3_led", led, 8'h22);

    // 4: load reg1/reg2, then pointer write + Sr + read with ACK then NACK
    i2c_start();
    wr_byte(8'h84, 1'b1);
    wr_byte(8'h01, 1'b1);
    wr_data(8'h5A, 8'h22);
    wr_data(8'hC3, 8'h22);
    i2c_stop();
    i2c_start();
    wr_byte(8'h84, 1'b1);
    wr_byte(8'h01, 1'b1);
    i2c_start();
    wr_byte(8'h85, 1'b1);
    rd_byte(8'h5A, 1'b1);
    rd_byte(8'hC3, 1'b0);
    check("t4_released_after_nack", sda_oe, 0);
    i2c_stop();
    check("t4_busy_after_stop", busy, 0);

    // 4b: read from reg3 wraps to reg0
    i2c_start();
    wr_byte(8'h84, 1'b1);
    wr_byte(8'h03, 1'b1);
    i2c_start();
    wr_byte(8'h85, 1'b1);
    rd_byte(8'h11, 1'b1);
    rd_byte(8'h22, 1'b0);
    i2c_stop();

    // 5: STOP after 4 data bits discards the partial byte
    i2c_start();
    wr_byte(8'h84, 1'b1);
    wr_byte(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) bit_cycle(1'b0, 1'b0, 1'b0);
    i2c_stop();
    check("t5_busy", busy, 0);
    check("t5_led_unchanged", led, 8'h22);

    // 6: reset in the middle of a data byte, then a clean transaction
    i2c_start();
    wr_byte(8'h84, 1'b1);
    wr_byte(8'h00, 1'b1);
    for (int i = 0; i < 4; i++) bit_cycle(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_led_reset", led, 0);
    check("t6_sda_oe_reset", sda_oe, 0);
    check("t6_busy_reset", busy, 0);
    @(posedge clk);
    rst = 1'b0;
    wait_clk(Q);
    i2c_stop();
    i2c_start();
    wr_byte(8'h84, 1'b1);
    wr_byte(8'h00, 1'b1);
    wr_data(8'h3C, 8'h3C);
    i2c_stop();
    check("t6_busy_after_stop", busy, 0);

    wait_clk(10);
    check("exp_bus_drained", exp_bus.size(), 0);
    check("exp_wr_drained", exp_wr.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    errors++;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
